// File: rtl/tiger_trace_tx.sv
// Tiger trace transmitter: captures instruction, cache-hang and cycle-count events
// as 3-word records, queues them, and streams them out on a 32-bit valid/ready port.
`timescale 1ns/1ps
module tiger_trace_tx #(
  parameter logic [31:0] START_PC    = 32'h0080_0000,
  parameter logic [31:0] FINISH_PC   = 32'h0080_0004,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned STALL_LIMIT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic        insValid,
  input  logic        iCacheStall,
  input  logic        dCacheStall,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        running,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [63:0] count;
  logic [23:0] seq;
  logic [31:0] pc_last;
  logic [9:0]  istall_cnt, dstall_cnt;
  logic        ialarm_pend, dalarm_pend, end_pushed;

  // Record layout: {tag[7:0], seq[23:0], hi[31:0], lo[31:0]}
  logic [95:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic [95:0]   rd_rec;

  logic [31:0] hi_r, lo_r;
  logic [1:0]  word_idx;

  logic        start_hit, cap, ins_room, any_room;
  logic        push, drop, clr_i, clr_d, push_end, pop, xfer, ser_free;
  logic        ialarm_set, dalarm_set;
  logic [95:0] push_rec;

  assign start_hit  = (state == S_IDLE) && (pc == START_PC);
  assign cap        = (start_hit || (state == S_RUN)) && insValid && (pc != pc_last);
  assign ins_room   = occ < (AW+1)'(FIFO_DEPTH - 1);
  assign any_room   = occ < (AW+1)'(FIFO_DEPTH);
  assign ialarm_set = (state == S_RUN) && iCacheStall && (istall_cnt == 10'(STALL_LIMIT - 1));
  assign dalarm_set = (state == S_RUN) && dCacheStall && (dstall_cnt == 10'(STALL_LIMIT - 1));

  assign rd_rec   = mem[rd_ptr];
  assign xfer     = tx_valid && tx_ready;
  assign ser_free = !tx_valid || (xfer && (word_idx == 2'd2));
  assign pop      = ser_free && (occ != '0);

  // A dropped instruction record frees the push slot for a waiting alarm.
  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    drop     = 1'b0;
    clr_i    = 1'b0;
    clr_d    = 1'b0;
    push_end = 1'b0;
    if (cap && ins_room) begin
      push     = 1'b1;
      push_rec = {8'hA1, seq, pc, ins};
    end else begin
      drop = cap;
      if (any_room) begin
        if (ialarm_pend) begin
          push     = 1'b1;
          clr_i    = 1'b1;
          push_rec = {8'hA2, seq, 32'd1, count[31:0]};
        end else if (dalarm_pend) begin
          push     = 1'b1;
          clr_d    = 1'b1;
          push_rec = {8'hA2, seq, 32'd2, count[31:0]};
        end else if ((state == S_DRAIN) && !end_pushed) begin
          push     = 1'b1;
          push_end = 1'b1;
          push_rec = {8'hA3, seq, count[63:32], count[31:0]};
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pc == START_PC) state_nxt = S_RUN;
      S_RUN:   if (pc == FINISH_PC) state_nxt = S_DRAIN;
      S_DRAIN: if (end_pushed && (occ == '0) && !tx_valid) state_nxt = S_DONE;
      default: state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      running     <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
      seq         <= '0;
      pc_last     <= '1;
      istall_cnt  <= '0;
      dstall_cnt  <= '0;
      ialarm_pend <= 1'b0;
      dalarm_pend <= 1'b0;
      end_pushed  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      hi_r        <= '0;
      lo_r        <= '0;
      word_idx    <= '0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done    <= (state_nxt == S_DONE);
      if (drop) overflow <= 1'b1;

      if (start_hit)             count <= '0;
      else if (state == S_RUN)   count <= count + 64'd1;

      if (cap)      pc_last    <= pc;
      if (push)     seq        <= seq + 24'd1;
      if (push_end) end_pushed <= 1'b1;

      // Counters saturate at STALL_LIMIT so a long episode alarms only once.
      if ((state != S_RUN) || !iCacheStall)         istall_cnt <= '0;
      else if (istall_cnt != 10'(STALL_LIMIT))      istall_cnt <= istall_cnt + 10'd1;
      if ((state != S_RUN) || !dCacheStall)         dstall_cnt <= '0;
      else if (dstall_cnt != 10'(STALL_LIMIT))      dstall_cnt <= dstall_cnt + 10'd1;

      if (ialarm_set)  ialarm_pend <= 1'b1;
      else if (clr_i)  ialarm_pend <= 1'b0;
      if (dalarm_set)  dalarm_pend <= 1'b1;
      else if (clr_d)  dalarm_pend <= 1'b0;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occ <= occ + (AW+1)'(1);
      else if (!push && pop) occ <= occ - (AW+1)'(1);

      if (pop) begin
        tx_valid <= 1'b1;
        tx_data  <= rd_rec[95:64];
        hi_r     <= rd_rec[63:32];
        lo_r     <= rd_rec[31:0];
        word_idx <= 2'd0;
      end else if (xfer) begin
        case (word_idx)
          2'd0: begin
            tx_data  <= hi_r;
            word_idx <= 2'd1;
          end
          2'd1: begin
            tx_data  <= lo_r;
            word_idx <= 2'd2;
          end
          default: begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            word_idx <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule
